mp3_play_ctrl: RTL

Playback controller for the MP3 decoder streamer. It turns five raw push-button inputs into the song index, pause flag and volume byte that the streamer consumes, and it sequences song changes. It runs in the streamer's clock domain. Each song change forces a silence gap before playback resumes.

---
 rtl/mp3_play_ctrl_pkg.sv | 18 +
 rtl/mp3_play_ctrl_if.sv | 29 ++
 rtl/mp3_play_ctrl_btn_debounce.sv | 49 ++++
 rtl/mp3_play_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mp3_play_ctrl_pkg.sv
// Shared types and constants for the MP3 playback controller.
// Holds the FSM state enum and the button event indices.
package mp3_ctrl_pkg;

    typedef enum logic [1:0] {
        PLAY,
        PAUSE,
        SWITCH
    } state_e;

    localparam int EV_PAUSE = 0;
    localparam int EV_NEXT  = 1;
    localparam int EV_PREV  = 2;
    localparam int EV_VOLUP = 3;
    localparam int EV_VOLDN = 4;
    localparam int NUM_EV   = 5;

endpackage

// File: rtl/mp3_play_ctrl_if.sv
// Button/stream bus between the playback controller and its environment.
// master: drives buttons, MEM_ADDR, MUSIC_SIZE; slave: drives song/pause/volume.
interface mp3_play_ctrl_if;

    logic        BTN_NEXT;
    logic        BTN_PREV;
    logic        BTN_PAUSE;
    logic        BTN_VOLUP;
    logic        BTN_VOLDN;
    logic [31:0] MEM_ADDR;
    logic [31:0] MUSIC_SIZE;
    logic [31:0] SONG_NOW;
    logic        IS_SUSPENDING;
    logic [7:0]  VOLUME;
    logic        SONG_CHANGED;

    modport master (
        output BTN_NEXT, BTN_PREV, BTN_PAUSE, BTN_VOLUP, BTN_VOLDN,
        output MEM_ADDR, MUSIC_SIZE,
        input  SONG_NOW, IS_SUSPENDING, VOLUME, SONG_CHANGED
    );

    modport slave (
        input  BTN_NEXT, BTN_PREV, BTN_PAUSE, BTN_VOLUP, BTN_VOLDN,
        input  MEM_ADDR, MUSIC_SIZE,
        output SONG_NOW, IS_SUSPENDING, VOLUME, SONG_CHANGED
    );

endinterface

// File: rtl/mp3_play_ctrl_btn_debounce.sv
// One button: 2-flop synchronizer, debouncer, one-cycle press pulse.
// Ports: clk_i, rst_ni, btn_i (raw), press_o (pulse on accepted 0->1).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    // Counter runs only while the synchronized level disagrees with the
    // accepted level; any return to the accepted level restarts it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q != level_q) begin
                if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                    level_q <= sync2_q;
                    press_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/mp3_play_ctrl.sv
// MP3 playback controller: buttons -> song index, pause flag, volume.
// Ports: CLK, RESET_N, io (slave). Optional macro: MP3_AUTO_NEXT_EN.
module mp3_play_ctrl
    import mp3_ctrl_pkg::*;
#(
    parameter int         NUM_SONGS       = 4,
    parameter int         DEBOUNCE_CYCLES = 1000000,
    parameter int         SWITCH_GAP      = 2048,
    parameter logic [7:0] VOL_DEFAULT     = 8'h20,
    parameter logic [7:0] VOL_STEP        = 8'h10,
    parameter logic [7:0] VOL_MAX_ATTN    = 8'hF0
) (
    input  logic CLK,
    input  logic RESET_N,
    mp3_play_ctrl_if.slave io
);

    localparam int GW = $clog2(SWITCH_GAP + 1);
    localparam logic [NUM_EV-1:0] VOL_MASK =
        NUM_EV'((1 << EV_VOLUP) | (1 << EV_VOLDN));

    logic [NUM_EV-1:0] btn_raw;
    logic [NUM_EV-1:0] press;
    logic [NUM_EV-1:0] pending_q;
    logic [NUM_EV-1:0] elig;
    logic [NUM_EV-1:0] sel;
    state_e            state_q;
    state_e            ret_q;
    logic [GW-1:0]     gap_q;
    logic [31:0]       song_q;
    logic              susp_q;
    logic [7:0]        vol_q;
    logic              chg_q;
    logic [31:0]       song_inc;
    logic [31:0]       song_dec;
    logic [7:0]        vol_up;
    logic [8:0]        vol_sum;
    logic [7:0]        vol_dn;
    logic              auto_next;

    assign btn_raw[EV_PAUSE] = io.BTN_PAUSE;
    assign btn_raw[EV_NEXT]  = io.BTN_NEXT;
    assign btn_raw[EV_PREV]  = io.BTN_PREV;
    assign btn_raw[EV_VOLUP] = io.BTN_VOLUP;
    assign btn_raw[EV_VOLDN] = io.BTN_VOLDN;

    for (genvar g = 0; g < NUM_EV; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk_i  (CLK),
            .rst_ni (RESET_N),
            .btn_i  (btn_raw[g]),
            .press_o(press[g])
        );
    end

    // Song changes wait out the gap; volume is still serviced in SWITCH.
    always_comb begin
        elig = pending_q;
        if (state_q == SWITCH) elig = pending_q & VOL_MASK;
        sel = '0;
        for (int i = NUM_EV - 1; i >= 0; i--) begin
            if (elig[i]) sel = NUM_EV'(1 << i);
        end
    end

    assign song_inc = (song_q == 32'(NUM_SONGS - 1)) ? 32'd0 : song_q + 32'd1;
    assign song_dec = (song_q == 32'd0) ? 32'(NUM_SONGS - 1) : song_q - 32'd1;

    // 9-bit sum so a large attenuation can never wrap back to loud.
    assign vol_up  = (vol_q >= VOL_STEP) ? vol_q - VOL_STEP : 8'h00;
    assign vol_sum = {1'b0, vol_q} + {1'b0, VOL_STEP};
    assign vol_dn  = (vol_sum > {1'b0, VOL_MAX_ATTN}) ? VOL_MAX_ATTN
                                                      : vol_sum[7:0];

`ifdef MP3_AUTO_NEXT_EN
    assign auto_next = (state_q == PLAY) && (elig == '0) &&
                       (io.MUSIC_SIZE != 32'd0) &&
                       (io.MEM_ADDR >= io.MUSIC_SIZE);
`else
    logic unused_stream;
    assign unused_stream = ^{io.MEM_ADDR, io.MUSIC_SIZE};
    assign auto_next     = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pending_q <= '0;
            state_q   <= PLAY;
            ret_q     <= PLAY;
            gap_q     <= '0;
            song_q    <= '0;
            susp_q    <= 1'b0;
            vol_q     <= VOL_DEFAULT;
            chg_q     <= 1'b0;
        end else begin
            pending_q <= (pending_q & ~sel) | press;
            chg_q     <= 1'b0;
            case (state_q)
                SWITCH: begin
                    if (gap_q == '0) begin
                        state_q <= ret_q;
                        susp_q  <= (ret_q == PAUSE);
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: begin
                    if (sel[EV_PAUSE]) begin
                        state_q <= (state_q == PLAY) ? PAUSE : PLAY;
                        susp_q  <= (state_q == PLAY);
                    end else if (sel[EV_NEXT] || sel[EV_PREV] || auto_next) begin
                        song_q  <= sel[EV_PREV] ? song_dec : song_inc;
                        chg_q   <= 1'b1;
                        ret_q   <= state_q;
                        state_q <= SWITCH;
                        susp_q  <= 1'b1;
                        gap_q   <= GW'(SWITCH_GAP - 1);
                    end
                end
            endcase
            unique case (1'b1)
                sel[EV_VOLUP]: vol_q <= vol_up;
                sel[EV_VOLDN]: vol_q <= vol_dn;
                default:       vol_q <= vol_q;
            endcase
        end
    end

    assign io.SONG_NOW      = song_q;
    assign io.IS_SUSPENDING = susp_q;
    assign io.VOLUME        = vol_q;
    assign io.SONG_CHANGED  = chg_q;

endmodule
